// File: rtl/mult_div.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers and mthi/mtlo writes.
// Optional macro MD_DIV0_HOLD_EN: when defined, division by zero leaves HI/LO unchanged.
module mult_div #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    state_t      state;
    logic [3:0]  count;
    logic [31:0] opA;
    logic [31:0] opB;
    logic [1:0]  opSel;

    logic        isSigned;
    logic        isDiv;
    logic [63:0] extA;
    logic [63:0] extB;
    logic [63:0] product;
    logic [31:0] absA;
    logic [31:0] absB;
    logic [31:0] divisor;
    logic [31:0] quot;
    logic [31:0] rem;
    logic [31:0] resHi;
    logic [31:0] resLo;

    // Signed division works on magnitudes and fixes signs afterwards, so the
    // 0x80000000 / -1 overflow naturally wraps to quotient 0x80000000, remainder 0.
    always_comb begin
        isSigned = ~opSel[0];
        isDiv    = opSel[1];
        extA     = isSigned ? {{32{opA[31]}}, opA} : {32'b0, opA};
        extB     = isSigned ? {{32{opB[31]}}, opB} : {32'b0, opB};
        product  = extA * extB;
        absA     = (isSigned && opA[31]) ? (~opA + 32'd1) : opA;
        absB     = (isSigned && opB[31]) ? (~opB + 32'd1) : opB;
        divisor  = (absB == 32'd0) ? 32'd1 : absB;
        quot     = absA / divisor;
        rem      = absA % divisor;
        resHi    = product[63:32];
        resLo    = product[31:0];
        if (isDiv) begin
            if (opB == 32'd0) begin
`ifdef MD_DIV0_HOLD_EN
                resHi = HI;
                resLo = LO;
`else
                resHi = opA;
                resLo = 32'hFFFF_FFFF;
`endif
            end else begin
                resLo = (isSigned && (opA[31] ^ opB[31])) ? (~quot + 32'd1) : quot;
                resHi = (isSigned && opA[31]) ? (~rem + 32'd1) : rem;
            end
        end
    end

    // Operands are captured at the start edge; the counter runs down to 1 and the
    // result is committed on the edge that ends the final busy cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            count <= 4'd0;
            opA   <= 32'd0;
            opB   <= 32'd0;
            opSel <= 2'd0;
            HI    <= 32'd0;
            LO    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        opA   <= A;
                        opB   <= B;
                        opSel <= op;
                        count <= op[1] ? DIV_LOAD : MULT_LOAD;
                        state <= BUSY;
                        busy  <= 1'b1;
                    end else begin
                        if (hi_we) HI <= wdata;
                        if (lo_we) LO <= wdata;
                    end
                end
                BUSY: begin
                    if (count <= 4'd1) begin
                        HI    <= resHi;
                        LO    <= resLo;
                        count <= 4'd0;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div.sv
// Directed self-checking bench for mult_div: arithmetic, busy timing, mthi/mtlo,
// divide-by-zero (honours MD_DIV0_HOLD_EN), reset abort and back-to-back launches.
module tb_mult_div;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks;
    int failures;

    mult_div dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .HI    (HI),
        .LO    (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launch an op at the next edge, then count busy cycles (bounded) until it drops.
    task automatic runOp(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit scramble, output int cycles);
        @(negedge clk);
        op = o; A = a; B = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cycles = 0;
        while (busy === 1'b1 && cycles < 40) begin
            cycles++;
            if (scramble) begin
                A = $urandom;
                B = $urandom;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic writeHiLo(input logic wh, input logic wl, input logic [31:0] d);
        @(negedge clk);
        hi_we = wh; lo_we = wl; wdata = d;
        @(posedge clk); #1;
        hi_we = 1'b0; lo_we = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; op = 2'd0; A = 32'd0; B = 32'd0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = 32'd0;
        #12;
        checks++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            failures++;
            $display("[TB] FAIL reset_state: busy=%b HI=%h LO=%h, required 0/0/0", busy, HI, LO);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_mult;
        int cyc;
        runOp(2'b00, 32'hFFFF_FFFE, 32'd3, 1'b0, cyc);
        checks++;
        if (cyc !== 5) begin
            failures++;
            $display("[TB] FAIL mult_busy: cycles=%0d, required 5", cyc);
        end
        checks++;
        if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFA) begin
            failures++;
            $display("[TB] FAIL mult_result: HI=%h LO=%h, required ffffffff fffffffa", HI, LO);
        end
        runOp(2'b01, 32'hFFFF_FFFE, 32'd3, 1'b0, cyc);
        checks++;
        if (cyc !== 5 || HI !== 32'h0000_0002 || LO !== 32'hFFFF_FFFA) begin
            failures++;
            $display("[TB] FAIL multu_result: cycles=%0d HI=%h LO=%h, required 5 00000002 fffffffa", cyc, HI, LO);
        end
    endtask

    task automatic test_div;
        int cyc;
        runOp(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, cyc);
        checks++;
        if (cyc !== 10) begin
            failures++;
            $display("[TB] FAIL div_busy: cycles=%0d, required 10", cyc);
        end
        checks++;
        if (LO !== 32'hFFFF_FFFD || HI !== 32'hFFFF_FFFF) begin
            failures++;
            $display("[TB] FAIL div_neg_dividend: HI=%h LO=%h, required ffffffff fffffffd", HI, LO);
        end
        // 7 / -2 -> quotient -3, remainder +1 (sign of dividend)
        runOp(2'b10, 32'd7, 32'hFFFF_FFFE, 1'b0, cyc);
        checks++;
        if (LO !== 32'hFFFF_FFFD || HI !== 32'd1) begin
            failures++;
            $display("[TB] FAIL div_neg_divisor: HI=%h LO=%h, required 00000001 fffffffd", HI, LO);
        end
        runOp(2'b11, 32'd7, 32'd2, 1'b0, cyc);
        checks++;
        if (LO !== 32'd3 || HI !== 32'd1) begin
            failures++;
            $display("[TB] FAIL divu_result: HI=%h LO=%h, required 00000001 00000003", HI, LO);
        end
        runOp(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, cyc);
        checks++;
        if (LO !== 32'h8000_0000 || HI !== 32'd0) begin
            failures++;
            $display("[TB] FAIL div_overflow: HI=%h LO=%h, required 00000000 80000000", HI, LO);
        end
    endtask

    task automatic test_mthi_mtlo;
        int cyc;
        writeHiLo(1'b1, 1'b0, 32'h1234_5678);
        checks++;
        if (HI !== 32'h1234_5678) begin
            failures++;
            $display("[TB] FAIL mthi: HI=%h, required 12345678", HI);
        end
        writeHiLo(1'b1, 1'b1, 32'hCAFE_F00D);
        checks++;
        if (HI !== 32'hCAFE_F00D || LO !== 32'hCAFE_F00D) begin
            failures++;
            $display("[TB] FAIL mthi_mtlo_both: HI=%h LO=%h, required cafef00d cafef00d", HI, LO);
        end
        // start together with lo_we: the write is dropped, LO still holds old value mid-op
        @(negedge clk);
        op = 2'b01; A = 32'd2; B = 32'd3; start = 1'b1; lo_we = 1'b1; wdata = 32'h0BAD_0BAD;
        @(posedge clk); #1;
        start = 1'b0; lo_we = 1'b0;
        checks++;
        if (LO !== 32'hCAFE_F00D || busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL start_drops_mtlo: LO=%h busy=%b, required cafef00d 1", LO, busy);
        end
        // writes during busy are ignored and HI holds
        @(negedge clk);
        hi_we = 1'b1; wdata = 32'h5555_5555;
        @(posedge clk); #1;
        checks++;
        if (HI !== 32'hCAFE_F00D) begin
            failures++;
            $display("[TB] FAIL mthi_while_busy: HI=%h, required cafef00d", HI);
        end
        hi_we = 1'b0;
        cyc = 0;
        while (busy === 1'b1 && cyc < 40) begin
            cyc++;
            @(posedge clk); #1;
        end
        checks++;
        if (HI !== 32'd0 || LO !== 32'd6) begin
            failures++;
            $display("[TB] FAIL multu_after_writes: HI=%h LO=%h, required 00000000 00000006", HI, LO);
        end
    endtask

    task automatic test_div0;
        int cyc;
        logic [31:0] expHi;
        logic [31:0] expLo;
        writeHiLo(1'b1, 1'b0, 32'hAAAA_0000);
        writeHiLo(1'b0, 1'b1, 32'h0000_5555);
        runOp(2'b11, 32'd5, 32'd0, 1'b0, cyc);
`ifdef MD_DIV0_HOLD_EN
        expHi = 32'hAAAA_0000;
        expLo = 32'h0000_5555;
`else
        expHi = 32'd5;
        expLo = 32'hFFFF_FFFF;
`endif
        checks++;
        if (cyc !== 10) begin
            failures++;
            $display("[TB] FAIL div0_busy: cycles=%0d, required 10", cyc);
        end
        checks++;
        if (HI !== expHi || LO !== expLo) begin
            failures++;
            $display("[TB] FAIL div0_result: HI=%h LO=%h, required %h %h", HI, LO, expHi, expLo);
        end
    endtask

    task automatic test_reset_during_busy;
        writeHiLo(1'b1, 1'b1, 32'h7777_7777);
        @(negedge clk);
        op = 2'b00; A = 32'd9; B = 32'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            failures++;
            $display("[TB] FAIL reset_abort_now: busy=%b HI=%h LO=%h, required 0/0/0", busy, HI, LO);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            failures++;
            $display("[TB] FAIL reset_no_late_commit: busy=%b HI=%h LO=%h, required 0/0/0", busy, HI, LO);
        end
    endtask

    task automatic test_back_to_back;
        int cyc;
        runOp(2'b01, 32'd3, 32'd4, 1'b1, cyc);
        checks++;
        if (cyc !== 5 || HI !== 32'd0 || LO !== 32'd12) begin
            failures++;
            $display("[TB] FAIL latched_operands: cycles=%0d HI=%h LO=%h, required 5 00000000 0000000c", cyc, HI, LO);
        end
        // first idle cycle after busy fell: launch immediately
        op = 2'b11; A = 32'd100; B = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL back_to_back_launch: busy=%b, required 1", busy);
        end
        cyc = 0;
        while (busy === 1'b1 && cyc < 40) begin
            cyc++;
            A = $urandom;
            B = $urandom;
            @(posedge clk); #1;
        end
        checks++;
        if (cyc !== 10 || LO !== 32'd14 || HI !== 32'd2) begin
            failures++;
            $display("[TB] FAIL back_to_back_result: cycles=%0d HI=%h LO=%h, required 10 00000002 0000000e", cyc, HI, LO);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_mult();
        test_div();
        test_mthi_mtlo();
        test_div0();
        test_reset_during_busy();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
